// File: rtl/spi_cs_arbiter.sv
// Round-robin arbiter and sequencer that shares one SPI master between MPU, shift register and flash.
// It drives one chip-select for the latched number of SCLK cycles, then holds an idle gap.
module spi_cs_arbiter #(
    parameter int CNT_W      = 13,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [2:0]         req_i,
    input  logic [3*CNT_W-1:0] req_len_i,
    input  logic [2:0]         req_nrw_i,
    input  logic               abort_i,
    output logic [2:0]         gnt_o,
    output logic [2:0]         done_o,
    output logic               aborted_o,
    output logic               cs_mpu_o,
    output logic               cs_shift_reg_o,
    output logic               cs_flash_o,
    output logic [CNT_W-1:0]   data_size_o,
    output logic               master_mode_nrw_o,
    output logic               busy_o
);

    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GAP_W   = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         prio_q, prio_d;
    logic [1:0]         win_q, win_d;
    logic [CNT_W-1:0]   size_q, size_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               abort_flag_q, abort_flag_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [2:0]         cs_q, cs_d;
    logic [2:0]         done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               busy_q, busy_d;

    logic [1:0]         cand0, cand1, cand2;
    logic [1:0]         win_sel;
    logic [CNT_W-1:0]   len_sel;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Search upward from the priority pointer, wrapping modulo 3.
    always_comb begin
        cand0 = prio_q;
        cand1 = (prio_q == 2'd2) ? 2'd0 : prio_q + 2'd1;
        cand2 = (prio_q == 2'd0) ? 2'd2 : prio_q - 2'd1;
        if (req_i[cand0]) begin
            win_sel = cand0;
        end else if (req_i[cand1]) begin
            win_sel = cand1;
        end else begin
            win_sel = cand2;
        end
    end

    always_comb begin
        case (win_sel)
            2'd0:    len_sel = req_len_i[0*CNT_W +: CNT_W];
            2'd1:    len_sel = req_len_i[1*CNT_W +: CNT_W];
            default: len_sel = req_len_i[2*CNT_W +: CNT_W];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        win_d        = win_q;
        size_d       = size_q;
        mode_d       = mode_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        abort_flag_d = abort_flag_q;
        gnt_d        = gnt_q;
        cs_d         = cs_q;
        done_d       = 3'b000;
        aborted_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i != 3'b000) begin
                    win_d   = win_sel;
                    size_d  = len_sel;
                    mode_d  = req_nrw_i[win_sel];
                    prio_d  = (win_sel == 2'd2) ? 2'd0 : win_sel + 2'd1;
                    gnt_d   = onehot(win_sel);
                    cs_d    = 3'b000;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                bit_cnt_d = size_q;
                if (size_q == '0) begin
                    gnt_d     = 3'b000;
                    done_d    = onehot(win_q);
                    aborted_d = abort_flag_q;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = S_GAP;
                end else begin
                    cs_d    = onehot(win_q);
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                bit_cnt_d = bit_cnt_q - 1'b1;
                // bit_cnt reaching 1 marks the last of exactly len chip-select cycles.
                if (abort_i || (bit_cnt_q == CNT_W'(1))) begin
                    abort_flag_d = abort_i;
                    aborted_d    = abort_i;
                    done_d       = onehot(win_q);
                    gnt_d        = 3'b000;
                    cs_d         = 3'b000;
                    gap_cnt_d    = GAP_LOAD;
                    state_d      = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    abort_flag_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
                cs_d    = 3'b000;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            prio_q       <= 2'd0;
            win_q        <= 2'd0;
            size_q       <= '0;
            mode_q       <= 1'b0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            abort_flag_q <= 1'b0;
            gnt_q        <= 3'b000;
            cs_q         <= 3'b000;
            done_q       <= 3'b000;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            win_q        <= win_d;
            size_q       <= size_d;
            mode_q       <= mode_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            abort_flag_q <= abort_flag_d;
            gnt_q        <= gnt_d;
            cs_q         <= cs_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt_o             = gnt_q;
    assign done_o            = done_q;
    assign aborted_o         = aborted_q;
    assign cs_mpu_o          = cs_q[0];
    assign cs_shift_reg_o    = cs_q[1];
    assign cs_flash_o        = cs_q[2];
    assign data_size_o       = size_q;
    assign master_mode_nrw_o = mode_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Directed bench for spi_cs_arbiter: every transaction is walked cycle by cycle against
// hand-derived expectations for grant, chip-select, completion and latched fields.
module tb_spi_cs_arbiter;

    localparam int CNT_W   = 13;
    localparam int GAP     = 2;
    localparam int MAX_LEN = (1 << CNT_W) - 1;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [2:0]         req_i;
    logic [3*CNT_W-1:0] req_len_i;
    logic [2:0]         req_nrw_i;
    logic               abort_i;
    logic [2:0]         gnt_o;
    logic [2:0]         done_o;
    logic               aborted_o;
    logic               cs_mpu_o;
    logic               cs_shift_reg_o;
    logic               cs_flash_o;
    logic [CNT_W-1:0]   data_size_o;
    logic               master_mode_nrw_o;
    logic               busy_o;
    logic [2:0]         cs_vec;

    int n_checks = 0;
    int n_fail   = 0;

    spi_cs_arbiter #(.CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .req_i             (req_i),
        .req_len_i         (req_len_i),
        .req_nrw_i         (req_nrw_i),
        .abort_i           (abort_i),
        .gnt_o             (gnt_o),
        .done_o            (done_o),
        .aborted_o         (aborted_o),
        .cs_mpu_o          (cs_mpu_o),
        .cs_shift_reg_o    (cs_shift_reg_o),
        .cs_flash_o        (cs_flash_o),
        .data_size_o       (data_size_o),
        .master_mode_nrw_o (master_mode_nrw_o),
        .busy_o            (busy_o)
    );

    assign cs_vec = {cs_flash_o, cs_shift_reg_o, cs_mpu_o};

    always #5 clk_i = ~clk_i;

    // Advance one clock; observation and driving happen 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int idx, input int len);
        req_len_i[idx*CNT_W +: CNT_W] = CNT_W'(len);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt_o), 0);
        chk({tag, "_cs"}, 32'(cs_vec), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
        chk({tag, "_aborted"}, 32'(aborted_o), 0);
        chk({tag, "_size"}, 32'(data_size_o), 0);
        chk({tag, "_mode"}, 32'(master_mode_nrw_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_gnt"}, 32'(gnt_o), 0);
        chk({tag, "_cs"}, 32'(cs_vec), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
    endtask

    // Called in an IDLE cycle whose request inputs are already driven; walks SETUP,
    // ACTIVE and every GAP cycle, stopping before the following IDLE cycle.
    task automatic expect_txn(input int w, input int len, input bit nrw, input int abort_at,
                              input bit drop_req, input bit scramble);
        logic [2:0] oh;
        int act;
        oh  = 3'b001 << w;
        act = (abort_at != 0) ? abort_at : len;
        step();
        chk("setup_gnt", 32'(gnt_o), 32'(oh));
        chk("setup_cs", 32'(cs_vec), 0);
        chk("setup_size", 32'(data_size_o), len);
        chk("setup_mode", 32'(master_mode_nrw_o), 32'(nrw));
        chk("setup_busy", 32'(busy_o), 1);
        chk("setup_done", 32'(done_o), 0);
        if (drop_req) req_i = 3'b000;
        for (int k = 1; k <= act; k++) begin
            step();
            chk("act_cs", 32'(cs_vec), 32'(oh));
            chk("act_gnt", 32'(gnt_o), 32'(oh));
            chk("act_size", 32'(data_size_o), len);
            chk("act_mode", 32'(master_mode_nrw_o), 32'(nrw));
            if (scramble && k == 2) begin
                for (int s = 0; s < 3; s++) set_len(s, $urandom_range(0, MAX_LEN - 1));
                req_nrw_i = 3'b000;
            end
            if (k == abort_at) abort_i = 1'b1;
        end
        step();
        abort_i = 1'b0;
        chk("done_pulse", 32'(done_o), 32'(oh));
        chk("done_aborted", 32'(aborted_o), 32'(abort_at != 0));
        chk("done_cs", 32'(cs_vec), 0);
        chk("done_gnt", 32'(gnt_o), 0);
        chk("done_busy", 32'(busy_o), 1);
        chk("done_size", 32'(data_size_o), len);
        chk("done_mode", 32'(master_mode_nrw_o), 32'(nrw));
        for (int g = 2; g <= GAP; g++) begin
            step();
            chk("gap_done", 32'(done_o), 0);
            chk("gap_aborted", 32'(aborted_o), 0);
            chk("gap_cs", 32'(cs_vec), 0);
            chk("gap_busy", 32'(busy_o), 1);
            chk("gap_size", 32'(data_size_o), len);
        end
    endtask

    initial begin
        rst_i     = 1'b0;
        req_i     = 3'b000;
        req_len_i = '0;
        req_nrw_i = 3'b000;
        abort_i   = 1'b0;

        // Reset state.
        step();
        step();
        chk_all_zero("reset");
        rst_i = 1'b1;

        // Single MPU request, len 16, read.
        req_i = 3'b001;
        set_len(0, 16);
        expect_txn(0, 16, 1'b0, 0, 1'b1, 1'b0);
        step();
        chk_idle("single_idle");

        // Fresh reset so full-load round-robin starts at MPU.
        rst_i = 1'b0;
        step();
        chk_all_zero("reset2");
        rst_i = 1'b1;
        req_i = 3'b111;
        for (int s = 0; s < 3; s++) set_len(s, 4);
        expect_txn(0, 4, 1'b0, 0, 1'b0, 1'b0);
        step();
        chk_idle("rr_idle0");
        expect_txn(1, 4, 1'b0, 0, 1'b0, 1'b0);
        step();
        chk_idle("rr_idle1");
        expect_txn(2, 4, 1'b0, 0, 1'b0, 1'b0);
        step();
        chk_idle("rr_idle2");
        expect_txn(0, 4, 1'b0, 0, 1'b1, 1'b0);
        step();
        chk_idle("rr_idle3");

        // Flash len 100 aborted on its 10th ACTIVE cycle.
        req_i = 3'b100;
        set_len(2, 100);
        expect_txn(2, 100, 1'b0, 10, 1'b1, 1'b0);
        step();
        chk_idle("abort_idle");

        // Next request completes normally with aborted_o low.
        req_i = 3'b001;
        set_len(0, 3);
        expect_txn(0, 3, 1'b0, 0, 1'b1, 1'b0);
        step();
        chk_idle("post_abort_idle");

        // Zero-length shift register transfer; abort_i held outside ACTIVE is ignored.
        req_i   = 3'b010;
        set_len(1, 0);
        abort_i = 1'b1;
        expect_txn(1, 0, 1'b0, 0, 1'b1, 1'b0);
        step();
        chk_idle("zero_idle");

        // Reset in the middle of a flash len 50 transfer.
        req_i = 3'b100;
        set_len(2, 50);
        step();
        chk("mid_setup_gnt", 32'(gnt_o), 32'(3'b100));
        req_i = 3'b000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mid_act_cs", 32'(cs_vec), 32'(3'b100));
        end
        rst_i = 1'b0;
        step();
        chk_all_zero("mid_reset");
        rst_i = 1'b1;
        req_i = 3'b111;
        for (int s = 0; s < 3; s++) set_len(s, 2);
        expect_txn(0, 2, 1'b0, 0, 1'b1, 1'b0);
        step();
        chk_idle("mid_after_idle");

        // Maximum length write; inputs scrambled during ACTIVE must not leak through.
        req_i     = 3'b001;
        set_len(0, MAX_LEN);
        req_nrw_i = 3'b001;
        expect_txn(0, MAX_LEN, 1'b1, 0, 1'b1, 1'b1);
        step();
        chk_idle("max_idle");
        chk("max_idle_size", 32'(data_size_o), MAX_LEN);
        chk("max_idle_mode", 32'(master_mode_nrw_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
